nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder that computes A+B+cin one nibble per clock.
- Shifts operand nibbles LSB-first into a single combinational 4-bit adder and carries between nibbles in a register.
- Sits directly upstream of the 4-bit adder: owns operand sequencing, carry feedback and result assembly.
- Valid/ready handshakes on both the input and output sides.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥4 (elaboration-time check fails otherwise).

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set on A/B/Ci is valid.
- in_ready  output  1  block can accept an operand set.
- A  input  WIDTH  operand A, sampled on accept.
- B  input  WIDTH  operand B, sampled on accept.
- Ci  input  1  carry-in, sampled on accept.
- out_valid  output  1  S/Cout hold a completed result.
- out_ready  input  1  downstream consumes the result.
- S  output  WIDTH  sum, registered.
- Cout  output  1  final carry-out, registered.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Derived constant: NIB = WIDTH/4. Nibble index counter width = clog2(NIB), minimum 1.

States and transitions:
- IDLE: in_ready=1, out_valid=0.
  - in_valid&&in_ready at an edge: capture A→a_sh, B→b_sh, Ci→carry; clear S and idx; go to RUN.
- RUN: in_ready=0.
  - Each edge: S[4*idx+3:4*idx] ← low nibble of a_sh[3:0]+b_sh[3:0]+carry; carry ← nibble carry-out.
  - Same edge: a_sh/b_sh shift right by 4; idx increments.
  - At the edge processing idx=NIB-1: Cout ← nibble carry-out; go to DONE.
- DONE: out_valid=1, in_ready=0.
  - S/Cout held stable.
  - out_valid&&out_ready at an edge: go to IDLE.
  - in_ready returns to 1 the cycle after that edge; there is no same-cycle restart.

Latency and throughput:
- Accept edge E0; nibbles computed on edges E1..E_NIB; out_valid high from E_NIB until the consume edge.
- Minimum spacing between accepts: NIB+2 cycles.

Handshake rules:
- in_valid ignored outside IDLE; operands are not re-sampled.
- out_valid never drops without out_ready.
- out_ready while out_valid=0 has no effect.

Arithmetic:
- Result is exact modulo 2^WIDTH; Cout is bit WIDTH of A+B+Ci.
- The carry register is the only inter-nibble path: no combinational path from A/B to S.
- S updates only in RUN, so S changes only after an accept.

Reset (async, any state, including mid-RUN):
- state=IDLE; in_ready=1 after reset release; out_valid=0; busy=0; S=0; Cout=0.
- carry, idx, a_sh, b_sh all 0.
- A partial result is discarded and no out_valid is produced.

Boundaries:
- NIB=1: a single RUN cycle.
- Carry wraps cleanly across every nibble, e.g. 0xFFFF+0x0000+1.
- in_valid held high continuously: exactly one accept per IDLE visit.

Decomposition:
- Shared package: state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the NIB/index-width derivation function, reused by other serial arithmetic blocks.
- One sub-module: the combinational nibble adder, instantiated once, using the team's existing four_bits_adder (4-bit A, B, Ci → S, Cout).
- FSM, shift registers, index counter and result assembly stay in the top level.

Test Plan (WIDTH=16):
- Reset release, then A=0x1234, B=0x1111, Ci=0 with in_valid pulse → in_ready drops at E0; out_valid rises exactly at E4; S=0x2345, Cout=0.
- A=0xFFFF, B=0x0001, Ci=0 → carry ripples through all 4 nibbles: S=0x0000, Cout=1. Then A=0xFFFF, B=0x0000, Ci=1 → S=0x0000, Cout=1.
- Result back-pressure: out_ready=0 for 10 cycles after out_valid → S/Cout/out_valid stable throughout; in_valid with new operands is ignored. Then out_ready=1 → in_ready=1 the next cycle; a later accept of 0x0001+0x0002 gives S=0x0003.
- rst_n asserted asynchronously between E2 and E3 of 0xABCD+0x1111 → all outputs 0 immediately, in_ready=1 after release, no out_valid. A fresh 0x0F0F+0x00F1, Ci=0 then gives S=0x1000, Cout=0.
- Random sweep of 1000 operand sets with random in_valid/out_ready gaps → every S/Cout matches the golden model {Cout,S}=A+B+Ci; accepted count equals delivered count.
- WIDTH=4 build: A=0x9, B=0x8, Ci=1 → out_valid at E1, S=0x2, Cout=1.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial arithmetic blocks.
// State encoding and nibble-count helpers.
package nibble_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nib_count(input int width);
    return width / 4;
  endfunction

  function automatic int idx_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// master drives operands and out_ready; slave is the adder.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             busy;

  modport master (
    output in_valid, A, B, Ci, out_ready,
    input  in_ready, out_valid, S, Cout, busy
  );

  modport slave (
    input  in_valid, A, B, Ci, out_ready,
    output in_ready, out_valid, S, Cout, busy
  );
endinterface

// File: rtl/four_bits_adder.sv
// Combinational 4-bit adder with carry in/out.
// Shared leaf cell of the serial arithmetic blocks.
module four_bits_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Ci,
  output logic [3:0] S,
  output logic       Cout
);

  assign {Cout, S} = {1'b0, A} + {1'b0, B} + {4'b0, Ci};

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder computing A+B+Ci one nibble per clock,
// LSB nibble first, carry held in a register between nibbles.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  nibble_serial_adder_if.slave bus
);

  localparam int NIB = nib_count(WIDTH);
  localparam int IW  = idx_width(NIB);
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4, >= 4");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_q;
  logic             carry;
  logic             cout_q;
  logic [IW-1:0]    idx;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [3:0]       nsum;
  logic             ncout;

  four_bits_adder u_add (
    .A    (a_sh[3:0]),
    .B    (b_sh[3:0]),
    .Ci   (carry),
    .S    (nsum),
    .Cout (ncout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      carry       <= 1'b0;
      idx         <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh       <= bus.A;
            b_sh       <= bus.B;
            carry      <= bus.Ci;
            s_q        <= '0;
            idx        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          // constant-index nibble writes
          for (int k = 0; k < NIB; k++) begin
            if (idx == IW'(k)) s_q[4*k +: 4] <= nsum;
          end
          carry <= ncout;
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            cout_q      <= ncout;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.S         = s_q;
  assign bus.Cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16 and 4).
// Reference: {Cout,S} = A+B+Ci computed in plain arithmetic.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   abort = 1'b0;

  nibble_serial_adder_if #(.WIDTH(16)) bus ();
  nibble_serial_adder_if #(.WIDTH(4))  bus4 ();

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  always #5 clk = ~clk;

  task automatic do_op(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    output logic [15:0] s,
    output logic        co,
    output int          lat
  );
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.Ci = ci;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    s = bus.S;
    co = bus.Cout;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.A = 0; bus.B = 0; bus.Ci = 0;
    bus.out_ready = 0;
    bus4.in_valid = 0; bus4.A = 0; bus4.B = 0; bus4.Ci = 0;
    bus4.out_ready = 0;
    rst_n = 1'b0;
    #12;
    total++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl got ov=%b busy=%b exp ov=0 busy=0",
               bus.out_valid, bus.busy);
    end
    total++;
    if (bus.S !== 16'h0 || bus.Cout !== 1'b0) begin
      bad++;
      $display("FAIL reset_data got S=%h C=%b exp S=0000 C=0",
               bus.S, bus.Cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1 || bus4.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got %b/%b exp 1/1",
               bus.in_ready, bus4.in_ready);
    end
  endtask

  task automatic test_latency();
    int early = 0;
    @(negedge clk);
    bus.A = 16'h1234; bus.B = 16'h1111; bus.Ci = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    total++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL accept got rdy=%b busy=%b exp rdy=0 busy=1",
               bus.in_ready, bus.busy);
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) early++;
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL early_valid got %0d early cycles exp 0", early);
    end
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL valid_at_e4 got %b exp 1", bus.out_valid);
    end
    total++;
    if (bus.S !== 16'h2345 || bus.Cout !== 1'b0) begin
      bad++;
      $display("FAIL sum_1234 got %h/%b exp 2345/0", bus.S, bus.Cout);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL consume got rdy=%b ov=%b exp 1/0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_carry();
    logic [15:0] s;
    logic        co;
    int          lat;
    do_op(16'hFFFF, 16'h0001, 1'b0, s, co, lat);
    total++;
    if (s !== 16'h0000 || co !== 1'b1 || lat != 4) begin
      bad++;
      $display("FAIL ripple_b1 got %h/%b lat=%0d exp 0000/1 lat=4",
               s, co, lat);
    end
    do_op(16'hFFFF, 16'h0000, 1'b1, s, co, lat);
    total++;
    if (s !== 16'h0000 || co !== 1'b1 || lat != 4) begin
      bad++;
      $display("FAIL ripple_ci got %h/%b lat=%0d exp 0000/1 lat=4",
               s, co, lat);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] s;
    logic        co;
    int          lat;
    int          w = 0;
    @(negedge clk);
    bus.A = 16'h1111; bus.B = 16'h2222; bus.Ci = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1;
      bus.A = 16'($urandom);
      bus.B = 16'($urandom);
      bus.Ci = 1'($urandom);
      total++;
      if (bus.out_valid !== 1'b1 || bus.S !== 16'h3333 ||
          bus.Cout !== 1'b0) begin
        bad++;
        $display("FAIL hold c=%0d got ov=%b %h/%b exp 1 3333/0",
                 c, bus.out_valid, bus.S, bus.Cout);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 ||
        bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL release got rdy=%b busy=%b ov=%b exp 1/0/0",
               bus.in_ready, bus.busy, bus.out_valid);
    end
    bus.in_valid = 1'b0;
    do_op(16'h0001, 16'h0002, 1'b0, s, co, lat);
    total++;
    if (s !== 16'h0003 || co !== 1'b0) begin
      bad++;
      $display("FAIL after_bp got %h/%b exp 0003/0", s, co);
    end
  endtask

  task automatic test_reset_midrun();
    logic [15:0] s;
    logic        co;
    int          lat;
    int          seen = 0;
    @(negedge clk);
    bus.A = 16'hABCD; bus.B = 16'h1111; bus.Ci = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.S !== 16'h0 || bus.Cout !== 1'b0) begin
      bad++;
      $display("FAIL async_rst got ov=%b busy=%b %h/%b exp 0 0 0000/0",
               bus.out_valid, bus.busy, bus.S, bus.Cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen++;
    end
    total++;
    if (bus.in_ready !== 1'b1 || seen != 0) begin
      bad++;
      $display("FAIL post_rst got rdy=%b stray_valid=%0d exp 1/0",
               bus.in_ready, seen);
    end
    do_op(16'h0F0F, 16'h00F1, 1'b0, s, co, lat);
    total++;
    if (s !== 16'h1000 || co !== 1'b0) begin
      bad++;
      $display("FAIL fresh got %h/%b exp 1000/0", s, co);
    end
  endtask

  task automatic test_random();
    logic [16:0] q[$];
    int acc = 0;
    int del = 0;
    @(negedge clk);
    fork
      begin : producer
        for (int i = 0; i < 1000 && !abort; i++) begin
          logic [15:0] a;
          logic [15:0] b;
          logic        ci;
          int          w;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          a = 16'($urandom);
          b = 16'($urandom);
          ci = 1'($urandom);
          bus.A = a; bus.B = b; bus.Ci = ci;
          bus.in_valid = 1'b1;
          w = 0;
          while (!bus.in_ready && w < 100) begin
            @(negedge clk);
            w++;
          end
          if (w >= 100) begin
            total++;
            bad++;
            $display("FAIL rand_accept_timeout op=%0d got no ready exp ready", i);
            abort = 1'b1;
          end else begin
            q.push_back({1'b0, a} + {1'b0, b} + {16'b0, ci});
            acc++;
            @(negedge clk);
            bus.in_valid = 1'b0;
          end
        end
        bus.in_valid = 1'b0;
      end
      begin : consumer
        int          cyc = 0;
        bit          hold = 1'b0;
        logic [16:0] hv = '0;
        logic [16:0] e;
        while (del < 1000 && !abort && cyc < 40000) begin
          @(negedge clk);
          cyc++;
          if (hold) begin
            total++;
            if (bus.out_valid !== 1'b1 || {bus.Cout, bus.S} !== hv) begin
              bad++;
              $display("FAIL rand_stable got ov=%b %h exp 1 %h",
                       bus.out_valid, {bus.Cout, bus.S}, hv);
            end
          end
          bus.out_ready = 1'($urandom);
          if (bus.out_valid && bus.out_ready) begin
            hold = 1'b0;
            total++;
            if (q.size() == 0) begin
              bad++;
              $display("FAIL rand_extra got result %h exp none",
                       {bus.Cout, bus.S});
            end else begin
              e = q.pop_front();
              if ({bus.Cout, bus.S} !== e) begin
                bad++;
                $display("FAIL rand_sum n=%0d got %h exp %h",
                         del, {bus.Cout, bus.S}, e);
              end
            end
            del++;
          end else if (bus.out_valid) begin
            hold = 1'b1;
            hv = {bus.Cout, bus.S};
          end else begin
            hold = 1'b0;
          end
        end
        if (cyc >= 40000) begin
          total++;
          bad++;
          $display("FAIL rand_timeout got %0d delivered exp 1000", del);
          abort = 1'b1;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
      end
    join
    total++;
    if (acc != del || acc != 1000) begin
      bad++;
      $display("FAIL rand_count got acc=%0d del=%0d exp 1000/1000",
               acc, del);
    end
  endtask

  task automatic test_width4();
    @(negedge clk);
    bus4.A = 4'h9; bus4.B = 4'h8; bus4.Ci = 1'b1;
    bus4.in_valid = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    total++;
    if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL w4_e0 got ov=%b rdy=%b exp 0/0",
               bus4.out_valid, bus4.in_ready);
    end
    @(negedge clk);
    total++;
    if (bus4.out_valid !== 1'b1 || bus4.S !== 4'h2 ||
        bus4.Cout !== 1'b1) begin
      bad++;
      $display("FAIL w4_e1 got ov=%b %h/%b exp 1 2/1",
               bus4.out_valid, bus4.S, bus4.Cout);
    end
    bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.out_ready = 1'b0;
    total++;
    if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL w4_consume got rdy=%b ov=%b exp 1/0",
               bus4.in_ready, bus4.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_carry();
    test_backpressure();
    test_reset_midrun();
    test_random();
    test_width4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
